// File: rtl/approx_add8_pipe_pkg.sv
// Shared constants and stage-1 payload type for the approximate 8-bit pipelined adder.
// With APPROX_ERR_MON_EN defined, the payload also carries the exact sum.
package approx_add8_pipe_pkg;

    localparam int DATA_W = 8;
    localparam int LSB_W  = 2;
    localparam int HI_W   = DATA_W - LSB_W;

    typedef struct packed {
        logic [LSB_W-1:0] s;
        logic             c2;
        logic [HI_W-1:0]  a_hi;
        logic [HI_W-1:0]  b_hi;
`ifdef APPROX_ERR_MON_EN
        logic [DATA_W:0]  exact;
`endif
    } s1_payload_t;

endpackage

// File: rtl/approx_lsb2.sv
// Combinational approximate 2-bit LSB segment: produces the low sum bits and
// a speculative carry into the exact upper segment.
module approx_lsb2
    import approx_add8_pipe_pkg::*;
(
    input  logic [LSB_W-1:0] a_i,
    input  logic [LSB_W-1:0] b_i,
    input  logic             cin_i,
    output logic [LSB_W-1:0] s_o,
    output logic             c2_o
);

    logic [LSB_W-1:0] and_ab;

    assign and_ab = a_i & b_i;
    assign s_o    = cin_i ? and_ab : ~and_ab;
    // Carry guessed from either operand having both LSBs set, or from cin.
    assign c2_o   = (a_i[0] & a_i[1]) | (b_i[0] & b_i[1]) | cin_i;

endmodule

// File: rtl/approx_add8_pipe.sv
// Two-stage valid/ready pipelined approximate 8-bit adder (approximate LSBs, exact MSBs).
// Optional mismatch monitor against the exact sum enabled by macro APPROX_ERR_MON_EN.
module approx_add8_pipe
    import approx_add8_pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              cout
`ifdef APPROX_ERR_MON_EN
    ,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  err_cnt
`endif
);

    // Handshake: a beat transfers on a rising edge where valid && ready; a stage
    // advances when it is empty or its downstream consumer advances this cycle.
    logic              s1_valid_q, s2_valid_q;
    logic              s1_adv, s2_adv;
    s1_payload_t       s1_q, s1_d;
    logic [DATA_W-1:0] sum_q;
    logic              cout_q;
    logic [HI_W:0]     hi_sum;
    logic [LSB_W-1:0]  lsb_s;
    logic              lsb_c2;

    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

    approx_lsb2 u_lsb (
        .a_i   (a[LSB_W-1:0]),
        .b_i   (b[LSB_W-1:0]),
        .cin_i (cin),
        .s_o   (lsb_s),
        .c2_o  (lsb_c2)
    );

    always_comb begin
        s1_d      = '0;
        s1_d.s    = lsb_s;
        s1_d.c2   = lsb_c2;
        s1_d.a_hi = a[DATA_W-1:LSB_W];
        s1_d.b_hi = b[DATA_W-1:LSB_W];
`ifdef APPROX_ERR_MON_EN
        s1_d.exact = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
`endif
    end

    assign hi_sum = {1'b0, s1_q.a_hi} + {1'b0, s1_q.b_hi} + {{HI_W{1'b0}}, s1_q.c2};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    sum_q  <= {hi_sum[HI_W-1:0], s1_q.s};
                    cout_q <= hi_sum[HI_W];
                end
            end
        end
    end

`ifdef APPROX_ERR_MON_EN
    logic [DATA_W:0]  exact_q;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             mismatch;

    assign mismatch = {cout_q, sum_q} != exact_q;
    assign err_cnt  = err_cnt_q;

    // Clear dominates a same-cycle increment; the count saturates at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (s2_valid_q && out_ready && mismatch && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exact_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            if (s2_adv && s1_valid_q) begin
                exact_q <= s1_q.exact;
            end
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_approx_add8_pipe.sv
// Self-checking bench for approx_add8_pipe: vector table, random traffic with
// backpressure, stall/reset corner cases; monitor checks run when APPROX_ERR_MON_EN is defined.
module tb_approx_add8_pipe;

  localparam int TB_CNT_W = 4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
`ifdef APPROX_ERR_MON_EN
  logic                err_clr;
  logic [TB_CNT_W-1:0] err_cnt;
  logic [TB_CNT_W-1:0] exp_err;
`endif

  int total = 0;
  int bad = 0;
  logic mon_en = 1'b0;
  // entries are {mismatch_vs_exact, cout, sum}
  logic [9:0] exp_q[$];

  approx_add8_pipe #(.CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef APPROX_ERR_MON_EN
    ,
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic mc);
    logic [1:0] ab;
    logic [1:0] s;
    logic       c2;
    logic [6:0] hi;
    logic [8:0] approx;
    logic [8:0] exact;
    ab     = ma[1:0] & mb[1:0];
    s      = mc ? ab : ~ab;
    c2     = (ma[0] & ma[1]) | (mb[0] & mb[1]) | mc;
    hi     = {1'b0, ma[7:2]} + {1'b0, mb[7:2]} + {6'b0, c2};
    approx = {hi, s};
    exact  = {1'b0, ma} + {1'b0, mb} + {8'b0, mc};
    return {approx != exact, approx};
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [7:0] ta, input logic [7:0] tbb, input logic tc, input logic [9:0] e);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    a = ta;
    b = tbb;
    cin = tc;
    in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) exp_q.push_back(e);
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [9:0] e;
    logic       deliver_mism;
    if (mon_en) begin
      deliver_mism = 1'b0;
      if (!rst_n) begin
`ifdef APPROX_ERR_MON_EN
        exp_err = '0;
`endif
      end else begin
`ifdef APPROX_ERR_MON_EN
        check("err_cnt_track", err_cnt, exp_err);
`endif
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got sum=%0h cout=%0b expected no output", sum, cout);
          end else begin
            e = exp_q.pop_front();
            check("result", {cout, sum}, e[8:0]);
            deliver_mism = e[9];
          end
        end
`ifdef APPROX_ERR_MON_EN
        if (err_clr) exp_err = '0;
        else if (deliver_mism && exp_err != {TB_CNT_W{1'b1}}) exp_err = exp_err + 1'b1;
`endif
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vc;
    logic [7:0] vsum;
    logic       vcout;
    logic       vmism;
  } vec_t;

  vec_t vecs[9];
  logic rand_done;

  initial begin
    vecs[0] = '{8'h03, 8'h00, 1'b0, 8'h07, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h20, 1'b0, 8'h33, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h03, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h04, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b0, 8'hFC, 1'b1, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0};
    vecs[8] = '{8'h80, 8'h80, 1'b0, 8'h03, 1'b1, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    out_ready = 1'b1;
    rand_done = 1'b0;
`ifdef APPROX_ERR_MON_EN
    err_clr = 1'b0;
    exp_err = '0;
`endif

    // reset state
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_in_ready", in_ready, 1);
    check("rst_release_out_valid", out_valid, 0);
`ifdef APPROX_ERR_MON_EN
    check("rst_err_cnt", err_cnt, 0);
`endif
    @(posedge clk);
    #1;

    // table vectors, back to back with out_ready high
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].va, vecs[i].vb, vecs[i].vc, {vecs[i].vmism, vecs[i].vcout, vecs[i].vsum});
    end
    drain();

    // random traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [7:0] ra;
          logic [7:0] rb;
          logic       rc;
          ra = 8'($urandom_range(0, 255));
          rb = 8'($urandom_range(0, 255));
          rc = 1'($urandom_range(0, 1));
          send(ra, rb, rc, model(ra, rb, rc));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // stall: two accepted, third blocked, output holds the first result
    out_ready = 1'b0;
    send(8'h03, 8'h00, 1'b0, {1'b1, 1'b0, 8'h07});
    send(8'hFF, 8'h01, 1'b1, {1'b0, 1'b1, 8'h01});
    a = 8'h10;
    b = 8'h20;
    cin = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_hold_sum", sum, 8'h07);
      check("stall_hold_cout", cout, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(8'h10, 8'h20, 1'b0, {1'b1, 1'b0, 8'h33});
    drain();

    // reset with both stages full
    out_ready = 1'b0;
    send(8'h55, 8'h0A, 1'b0, model(8'h55, 8'h0A, 1'b0));
    send(8'h3C, 8'hC3, 1'b1, model(8'h3C, 8'hC3, 1'b1));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
    check("midrst_in_ready", in_ready, 1);
`ifdef APPROX_ERR_MON_EN
    check("midrst_err_cnt", err_cnt, 0);
`endif
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h10, 8'h20, 1'b0, {1'b1, 1'b0, 8'h33});
    drain();

`ifdef APPROX_ERR_MON_EN
    // saturation, then clear coincident with a mismatching delivery
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    for (int i = 0; i < 18; i++) begin
      send(8'h03, 8'h00, 1'b0, {1'b1, 1'b0, 8'h07});
    end
    drain();
    @(negedge clk);
    check("err_saturated", err_cnt, {TB_CNT_W{1'b1}});
    @(posedge clk);
    #1;
    send(8'h03, 8'h00, 1'b0, {1'b1, 1'b0, 8'h07});
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(negedge clk);
    check("clr_vs_mismatch_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("clr_wins", err_cnt, 0);
    drain();
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
